// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode encoding, flag bit positions, opcode classification.
// ALU_PIPE_SAT_EN turns opcode F into a signed saturating add; otherwise it is reserved.
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_ADC   = 4'h2,
      OP_SBC   = 4'h3,
      OP_AND   = 4'h4,
      OP_OR    = 4'h5,
      OP_XOR   = 4'h6,
      OP_NOT   = 4'h7,
      OP_SHL   = 4'h8,
      OP_SHR   = 4'h9,
      OP_SRA   = 4'hA,
      OP_ROL   = 4'hB,
      OP_SLT   = 4'hC,
      OP_SLTU  = 4'hD,
      OP_PASSB = 4'hE,
`ifdef ALU_PIPE_SAT_EN
      OP_SADD  = 4'hF
`else
      OP_RSVD  = 4'hF
`endif
   } op_t;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   // Only the four carry-chain opcodes may update the internal carry register.
   function automatic logic is_arith(input op_t op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
   endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: computes the next result, {N,Z,C,V} flags and carry-load enable.
// Opcode F behaviour depends on ALU_PIPE_SAT_EN (saturating add vs. reserved zero).
module alu_pipe_core
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cf,
   output logic [WIDTH-1:0] res,
   output logic [3:0]       flg,
   output logic             cf_load
);

   op_t                  opc;
   logic [SHW-1:0]       sh;
   logic [WIDTH:0]       ext;
   logic [WIDTH-1:0]     sum;
   logic [2*WIDTH-1:0]   rot;
   logic                 carry;
   logic                 ovf;
   logic                 zero_flags;

   assign opc     = op_t'(op);
   assign sh      = b[SHW-1:0];
   assign rot     = {a, a} << sh;
   assign sum     = a + b;
   assign cf_load = is_arith(opc);

   // Arithmetic runs one bit wider so bit WIDTH is carry for adds and borrow for subtracts.
   always_comb begin
      ext        = '0;
      res        = '0;
      carry      = 1'b0;
      ovf        = 1'b0;
      zero_flags = 1'b0;
      unique case (opc)
         OP_ADD, OP_ADC: begin
            ext   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opc == OP_ADC) & cf};
            res   = ext[WIDTH-1:0];
            carry = ext[WIDTH];
            ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBC: begin
            ext   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opc == OP_SBC) & cf};
            res   = ext[WIDTH-1:0];
            carry = ext[WIDTH];
            ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:   res = a & b;
         OP_OR:    res = a | b;
         OP_XOR:   res = a ^ b;
         OP_NOT:   res = ~a;
         OP_SHL:   res = a << sh;
         OP_SHR:   res = a >> sh;
         OP_SRA:   res = WIDTH'($signed(a) >>> sh);
         OP_ROL:   res = rot[2*WIDTH-1:WIDTH];
         OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_PASSB: res = b;
`ifdef ALU_PIPE_SAT_EN
         OP_SADD: begin
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            if (!ovf)
               res = sum;
            else if (a[WIDTH-1])
               res = {1'b1, {(WIDTH-1){1'b0}}};
            else
               res = {1'b0, {(WIDTH-1){1'b1}}};
         end
`else
         OP_RSVD:  zero_flags = 1'b1;
`endif
         default:  res = '0;
      endcase
   end

   // The reserved opcode reports all-zero flags even though its result reads as zero.
   always_comb begin
      flg = 4'b0000;
      if (!zero_flags) begin
         flg[FLG_N] = res[WIDTH-1];
         flg[FLG_Z] = (res == '0);
         flg[FLG_C] = carry;
         flg[FLG_V] = ovf;
      end
   end

`ifndef ALU_PIPE_SAT_EN
   logic unused_sum;
   assign unused_sum = ^sum;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and a carry register for ADC/SBC chaining.
// Set ALU_PIPE_SAT_EN to make opcode F a signed saturating add.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic             cf;
   logic             accept;
   logic [WIDTH-1:0] next_res;
   logic [3:0]       next_flg;
   logic             cf_load;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   alu_pipe_core #(
      .WIDTH (WIDTH),
      .SHW   (SHW)
   ) u_core (
      .op      (op),
      .a       (a),
      .b       (b),
      .cf      (cf),
      .res     (next_res),
      .flg     (next_flg),
      .cf_load (cf_load)
   );

   // A new accept overwrites the output stage even during a handoff, so throughput stays at one per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= 4'b0000;
         cf        <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= next_res;
         flags     <= next_flg;
         if (cf_load)
            cf <= next_flg[FLG_C];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
